parity_rx: RTL and testbench

Serial frame receiver with parity check; the receive end of the team's parity generator path. It samples one bit per clock on rx_in and deframes start, DATA_W data bits (LSB first), one parity bit and one stop bit. It presents the recovered word with a one-cycle valid pulse, parity/framing error flags and a saturating error counter. It sits downstream of the parity generator / serializer in the bootcamp datapath.

---
 rtl/parity_rx.sv | 63 ++++++
 tb/tb_parity_rx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/parity_rx.sv
// parity_rx: serial frame deframer (start, LSB-first data, parity, stop) with error flags and saturating error count
module parity_rx #(
    parameter int DATA_W = 4,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int BW = $clog2(DATA_W) + 1;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t            state, state_nx;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              rx_par, par_bad, done;
    always_comb begin
        state_nx = state == IDLE   ? (rx_in ? IDLE : DATA) :
                   state == DATA   ? (bit_cnt == BW'(DATA_W - 1) ? PARITY : DATA) :
                   state == PARITY ? STOP : IDLE;
        done     = state == STOP;
        par_bad  = rx_par != ((^shift) ^ (ODD != 0));
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_par     <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state   <= state_nx;
            valid   <= done;
            bit_cnt <= state == DATA ? bit_cnt + 1'b1 : '0;
            // LSB arrives first, so after DATA_W shifts it has moved down to bit 0
            if (state == DATA)
                shift <= DATA_W'({rx_in, shift} >> 1);
            if (state == PARITY)
                rx_par <= rx_in;
            if (done) begin
                data_out   <= shift;
                parity_err <= par_bad;
                frame_err  <= !rx_in;
            end
            if (clr_err)
                err_cnt <= '0;
            else if (done && (par_bad || !rx_in) && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed checks of even- and odd-parity receivers
module tb_parity_rx;
    logic       clk = 0, n_rst = 0, sel = 0;
    logic       rx0 = 1, rx1 = 1, clr0 = 0, clr1 = 0;
    logic [3:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;
    logic [7:0] cnt0, cnt1;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    parity_rx #(.DATA_W(4), .ODD(0), .CNT_W(8)) u0 (
        .clk(clk), .n_rst(n_rst), .rx_in(rx0), .clr_err(clr0), .data_out(data0),
        .valid(valid0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0), .err_cnt(cnt0));
    parity_rx #(.DATA_W(4), .ODD(1), .CNT_W(8)) u1 (
        .clk(clk), .n_rst(n_rst), .rx_in(rx1), .clr_err(clr1), .data_out(data1),
        .valid(valid1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1), .err_cnt(cnt1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic b);
        @(negedge clk);
        if (sel) rx1 = b; else rx0 = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b1);
    endtask

    // ends 1 time unit after the stop-bit edge, where valid should be high
    task automatic frame(input logic [3:0] d, input logic p, input logic s, input logic c);
        put(1'b0);
        for (int i = 0; i < 4; i++) put(d[i]);
        put(p);
        put(s);
        if (sel) clr1 = c; else clr0 = c;
        @(posedge clk);
        #1;
        clr0 = 0;
        clr1 = 0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic pe, input logic fe, input logic [7:0] c);
        chk({tag, ".valid"}, sel ? valid1 : valid0, 1);
        chk({tag, ".data"}, sel ? data1 : data0, d);
        chk({tag, ".perr"}, sel ? perr1 : perr0, pe);
        chk({tag, ".ferr"}, sel ? ferr1 : ferr0, fe);
        chk({tag, ".cnt"}, sel ? cnt1 : cnt0, c);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outs", {data0, valid0, perr0, ferr0, busy0, cnt0}, 0);
        chk("rst.outs1", {data1, valid1, perr1, ferr1, busy1, cnt1}, 0);
        @(negedge clk);
        n_rst = 1;
        for (int i = 0; i < 20; i++) begin
            put(1'b1);
            @(posedge clk);
            #1;
            chk("idle.valid_busy", {valid0, busy0, data0, cnt0}, 0);
        end

        frame(4'b0010, 1, 1, 0);
        chk_out("f0010", 4'b0010, 0, 0, 0);
        idle(1);
        @(posedge clk);
        #1;
        chk("f0010.pulse_end", valid0, 0);
        chk("f0010.hold", data0, 4'b0010);

        frame(4'b0111, 0, 1, 0);
        chk_out("f0111_perr", 4'b0111, 1, 0, 1);
        frame(4'b0011, 0, 0, 0);
        chk_out("f0011_ferr", 4'b0011, 0, 1, 2);
        idle(2);

        frame(4'b0000, 0, 1, 0);
        chk_out("b2b_a", 4'b0000, 0, 0, 2);
        frame(4'b1111, 0, 1, 0);
        chk_out("b2b_b", 4'b1111, 0, 0, 2);
        idle(1);

        frame(4'b0111, 0, 1, 1);
        chk_out("clr_vs_err", 4'b0111, 1, 0, 0);
        idle(1);

        put(1'b0);
        put(1'b1);
        put(1'b0);
        put(1'b1);
        @(posedge clk);
        #1;
        chk("mid.busy", busy0, 1);
        n_rst = 0;
        #1;
        chk("mid_rst.outs", {data0, valid0, perr0, ferr0, busy0, cnt0}, 0);
        @(negedge clk);
        n_rst = 1;
        rx0 = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst.no_valid", {valid0, busy0}, 0);
        end
        frame(4'b1010, 0, 1, 0);
        chk_out("f1010", 4'b1010, 0, 0, 0);
        idle(2);

        sel = 1;
        frame(4'b0010, 0, 1, 0);
        chk_out("odd_ok", 4'b0010, 0, 0, 0);
        frame(4'b0010, 1, 1, 0);
        chk_out("odd_bad", 4'b0010, 1, 0, 1);
        for (int i = 0; i < 254; i++) frame(4'b0010, 1, 1, 0);
        chk_out("sat_255", 4'b0010, 1, 0, 255);
        frame(4'b0010, 1, 1, 0);
        chk_out("sat_hold", 4'b0010, 1, 0, 255);
        idle(2);
        chk("u0_quiet", {valid0, data0, cnt0}, {1'b0, 4'b1010, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
